// File: rtl/energy_pkg.sv
// Shared constants for the windowed sample statistics block.
package energy_pkg;

  localparam int unsigned DATA_W_DEF   = 8;
  localparam int unsigned WIN_LOG2_DEF = 4;

  // FSM encodings; ST_STALL is a view of ST_LAST and is never stored.
  localparam logic [1:0] ST_FILL  = 2'd0;
  localparam logic [1:0] ST_LAST  = 2'd1;
  localparam logic [1:0] ST_STALL = 2'd2;

  localparam logic [DATA_W_DEF-1:0] MIN_INIT = '1;
  localparam logic [DATA_W_DEF-1:0] MAX_INIT = '0;

endpackage

// File: rtl/minmax_tracker.sv
// Running minimum/maximum of accepted samples; clear reloads the empty-window values.
module minmax_tracker #(
  parameter int unsigned W = energy_pkg::DATA_W_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         enable,
  input  logic [W-1:0] sample,
  output logic [W-1:0] min_c,
  output logic [W-1:0] max_c
);

  localparam logic [W-1:0] MIN_EMPTY = {W{1'b1}};
  localparam logic [W-1:0] MAX_EMPTY = {W{1'b0}};

  logic [W-1:0] min_q;
  logic [W-1:0] max_q;

  // Extremes including the sample accepted this cycle.
  always_comb begin
    min_c = min_q;
    max_c = max_q;
    if (enable) begin
      if (sample < min_q) min_c = sample;
      if (sample > max_q) max_c = sample;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      min_q <= MIN_EMPTY;
      max_q <= MAX_EMPTY;
    end else if (clear) begin
      min_q <= MIN_EMPTY;
      max_q <= MAX_EMPTY;
    end else begin
      min_q <= min_c;
      max_q <= max_c;
    end
  end

endmodule

// File: rtl/sample_window_stats.sv
// Average/min/max over windows of 2^WIN_LOG2 samples, published on a valid/ready port.
module sample_window_stats
  import energy_pkg::*;
#(
  parameter int unsigned DATA_W   = DATA_W_DEF,
  parameter int unsigned WIN_LOG2 = WIN_LOG2_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_avg,
  output logic [DATA_W-1:0] out_min,
  output logic [DATA_W-1:0] out_max,
  output logic [7:0]        win_count
);

  localparam int unsigned ACC_W = DATA_W + WIN_LOG2;
  localparam logic [WIN_LOG2-1:0] PRE_LAST = WIN_LOG2'((1 << WIN_LOG2) - 2);

  logic [1:0]          state;
  logic [1:0]          state_nxt;
  logic [1:0]          dbg_state_c;
  logic [ACC_W-1:0]    acc;
  logic [ACC_W-1:0]    sum_c;
  logic [WIN_LOG2-1:0] count;
  logic                accept_c;
  logic                complete_c;
  logic [DATA_W-1:0]   run_min_c;
  logic [DATA_W-1:0]   run_max_c;

  // LAST reads as STALL while a finished result is still unconsumed.
  always_comb begin
    dbg_state_c = state;
    if (state == ST_LAST && out_valid && !out_ready) dbg_state_c = ST_STALL;
  end

  assign in_ready   = (dbg_state_c != ST_STALL);
  assign accept_c   = in_valid && in_ready;
  assign complete_c = accept_c && (state == ST_LAST);
  assign sum_c      = acc + ACC_W'(in_data);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_FILL;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_FILL: if (accept_c && count == PRE_LAST) state_nxt = ST_LAST;
      ST_LAST: if (accept_c)                      state_nxt = ST_FILL;
      default:                                    state_nxt = ST_FILL;
    endcase
  end

  minmax_tracker #(.W(DATA_W)) u_minmax (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (complete_c),
    .enable (accept_c),
    .sample (in_data),
    .min_c  (run_min_c),
    .max_c  (run_max_c)
  );

  // Accumulator and sample counter restart on the completing edge, no gap cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc   <= '0;
      count <= '0;
    end else if (complete_c) begin
      acc   <= '0;
      count <= '0;
    end else if (accept_c) begin
      acc   <= sum_c;
      count <= count + WIN_LOG2'(1);
    end
  end

  // A completion on the same edge as a consume keeps out_valid high with new data.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_avg   <= '0;
      out_min   <= '0;
      out_max   <= '0;
      win_count <= '0;
    end else if (complete_c) begin
      out_valid <= 1'b1;
      out_avg   <= DATA_W'(sum_c >> WIN_LOG2);
      out_min   <= run_min_c;
      out_max   <= run_max_c;
      win_count <= win_count + 8'd1;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sample_window_stats.sv
// Scoreboard bench for sample_window_stats: reference model pushes results, consumes pop and compare.
module tb_sample_window_stats;

  localparam int unsigned WIN_LOG2 = 4;
  localparam int unsigned WIN_LEN  = 1 << WIN_LOG2;

  typedef struct {
    logic [7:0] avg;
    logic [7:0] mn;
    logic [7:0] mx;
    logic [7:0] wc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_avg;
  logic [7:0] out_min;
  logic [7:0] out_max;
  logic [7:0] win_count;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  int   m_sum;
  int   m_cnt;
  int   m_min;
  int   m_max;
  int   m_win;
  logic m_valid;

  sample_window_stats #(.DATA_W(8), .WIN_LOG2(WIN_LOG2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_avg   (out_avg),
    .out_min   (out_min),
    .out_max   (out_max),
    .win_count (win_count)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  task automatic model_clear();
    m_sum = 0;
    m_cnt = 0;
    m_min = 255;
    m_max = 0;
  endtask

  // One clock: drive at negedge, check settled outputs, advance the model, take the edge.
  task automatic cycle(input logic v, input logic [7:0] d, input logic ordy);
    logic exp_ready;
    logic acc;
    logic done;
    logic cons;
    exp_t e;
    @(negedge clk);
    in_valid  = v;
    in_data   = d;
    out_ready = ordy;
    #1;
    exp_ready = !((m_cnt == WIN_LEN - 1) && m_valid && !ordy);
    acc  = v && exp_ready;
    done = acc && (m_cnt == WIN_LEN - 1);
    cons = m_valid && ordy;
    check_eq("out_valid", 32'(out_valid), 32'(m_valid));
    check_eq("in_ready", 32'(in_ready), 32'(exp_ready));
    if (cons) begin
      if (sb.size() == 0) begin
        check_eq("sb_underflow", 32'(sb.size()), 32'd1);
      end else begin
        e = sb.pop_front();
        check_eq("out_avg", 32'(out_avg), 32'(e.avg));
        check_eq("out_min", 32'(out_min), 32'(e.mn));
        check_eq("out_max", 32'(out_max), 32'(e.mx));
        check_eq("win_count", 32'(win_count), 32'(e.wc));
      end
    end
    if (acc) begin
      m_sum += int'(d);
      if (int'(d) < m_min) m_min = int'(d);
      if (int'(d) > m_max) m_max = int'(d);
      m_cnt++;
    end
    if (done) begin
      m_win = (m_win + 1) % 256;
      e.avg = 8'(m_sum >> WIN_LOG2);
      e.mn  = 8'(m_min);
      e.mx  = 8'(m_max);
      e.wc  = 8'(m_win);
      sb.push_back(e);
      model_clear();
    end
    if (done)      m_valid = 1'b1;
    else if (cons) m_valid = 1'b0;
    @(posedge clk);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    sb.delete();
    model_clear();
    m_win   = 0;
    m_valid = 1'b0;
    #1;
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_in_ready", 32'(in_ready), 32'd1);
    check_eq("rst_out_avg", 32'(out_avg), 32'd0);
    check_eq("rst_out_min", 32'(out_min), 32'd0);
    check_eq("rst_out_max", 32'(out_max), 32'd0);
    check_eq("rst_win_count", 32'(win_count), 32'd0);
  endtask

  initial begin
    rst_n     = 1'b1;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    out_ready = 1'b0;
    model_clear();
    m_win   = 0;
    m_valid = 1'b0;

    apply_reset();

    // Constant window, result consumed right away.
    for (int i = 0; i < 16; i++) cycle(1'b1, 8'h10, 1'b1);
    cycle(1'b0, 8'h00, 1'b1);

    // Two back-to-back ramps with no idle cycle between.
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < 16; i++) cycle(1'b1, 8'(i), 1'b1);
    cycle(1'b0, 8'h00, 1'b1);

    // Full-scale window.
    for (int i = 0; i < 16; i++) cycle(1'b1, 8'hFF, 1'b1);
    cycle(1'b0, 8'h00, 1'b1);

    // Backpressure: first result held, second window stalls on its final sample.
    for (int i = 0; i < 16; i++) cycle(1'b1, 8'(8'h20 + i), 1'b0);
    for (int i = 0; i < 15; i++) cycle(1'b1, 8'(8'h40 + 2 * i), 1'b0);
    for (int i = 0; i < 3; i++)  cycle(1'b1, 8'h99, 1'b0);
    cycle(1'b0, 8'h00, 1'b1);
    cycle(1'b1, 8'h99, 1'b0);
    cycle(1'b0, 8'h00, 1'b1);

    // Completion on the same edge that consumes the pending result.
    for (int i = 0; i < 16; i++) cycle(1'b1, 8'(8'h50 ^ i), 1'b0);
    for (int i = 0; i < 15; i++) cycle(1'b1, 8'(8'hC0 + i), 1'b0);
    cycle(1'b1, 8'h03, 1'b1);
    cycle(1'b0, 8'h00, 1'b1);

    // Reset mid-window discards the partial window.
    for (int i = 0; i < 5; i++) cycle(1'b1, 8'h80, 1'b1);
    apply_reset();
    for (int i = 0; i < 16; i++) cycle(1'b1, 8'h02, 1'b1);
    cycle(1'b0, 8'h00, 1'b1);

    // Random traffic with random backpressure and idle cycles.
    for (int i = 0; i < 400; i++)
      cycle(($urandom_range(0, 3) != 0), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));

    for (int i = 0; i < 3; i++) cycle(1'b0, 8'h00, 1'b1);
    check_eq("sb_empty", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
